// File: rtl/fork_outport_tx_pkg.sv
// Shared definitions for the fork_outport_tx link transmitter.
// Holds the FSM state encoding, which also appears on the debug port.
package fork_outport_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/fork_outport_tx_vc.sv
// Per-VC FIFO holding {head, data} entries, with a registered occupancy count.
// The parent only pushes when a slot is free or a pop happens in the same cycle.
module vc_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rs) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, a same-cycle push lands on the slot being read out, which is safe.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fork_outport_tx.sv
// Output-port link transmitter: per-VC FIFOs, round-robin VC selection with a
// burst cap, and a PROBE/SEND handshake against the downstream ready.
module fork_outport_tx
  import fork_outport_tx_pkg::*;
#(
  parameter int no_vc                      = 13,
  parameter int floorplusone_log2_no_vc    = 4,
  parameter int phit_size                  = 16,
  parameter int buf_size                   = 4,
  parameter int floorplusone_log2_buf_size = 3,
  parameter int max_burst                  = 8
) (
  input  logic                               clk,
  input  logic                               rs,
  input  logic [phit_size-1:0]               wr_data,
  input  logic                               wr_head,
  input  logic [floorplusone_log2_no_vc-1:0] wr_vc,
  input  logic                               wr_en,
  output logic [no_vc-1:0]                   full_vec,
  output logic                               ovf_err,
  output logic [phit_size-1:0]               outdata,
  output logic                               out_new,
  output logic                               outsent_req,
  output logic [floorplusone_log2_no_vc-1:0] outvc_no,
  input  logic                               ready,
  output state_t                             o_dbg_state
);
  localparam int VW = floorplusone_log2_no_vc;
  localparam int CW = floorplusone_log2_buf_size;
  localparam int BW = $clog2(max_burst) + 1;
  localparam int EW = phit_size + 1;

  // Handshake: a phit transfers in exactly the cycles where out_new=1, which
  // requires SEND, ready=1 and a non-empty current VC; outvc_no was set on
  // the edge into the preceding PROBE, so ready always refers to it.
  state_t          r_state, w_next_state;
  logic [VW-1:0]   r_cur_vc, r_rr_ptr, r_outvc_no;
  logic [BW-1:0]   r_burst_cnt;
  logic            r_ovf;

  logic [no_vc-1:0] w_empty, w_full, w_push, w_pop, w_wr_sel;
  logic [EW-1:0]    w_head_arr [no_vc];
  logic [CW-1:0]    w_count    [no_vc];
  logic             w_out_new, w_ovf, w_empty_after, w_burst_done, w_leave;
  logic [VW-1:0]    w_cur_inc, w_pick;
  logic             w_pick_valid;
  logic [no_vc-1:0] w_mask, w_mask_excl;
  int               w_start;

  for (genvar v = 0; v < no_vc; v++) begin : g_vc
    vc_fifo #(.WIDTH(EW), .DEPTH(buf_size), .CW(CW)) u_fifo (
      .clk     (clk),
      .rs      (rs),
      .i_push  (w_push[v]),
      .i_pop   (w_pop[v]),
      .i_din   ({wr_head, wr_data}),
      .o_head  (w_head_arr[v]),
      .o_count (w_count[v]),
      .o_empty (w_empty[v]),
      .o_full  (w_full[v])
    );
  end

  // FIFO write/pop control; a pop on a full VC frees room for a same-cycle write.
  always_comb begin
    w_ovf = 1'b0;
    for (int v = 0; v < no_vc; v++) begin
      w_wr_sel[v] = wr_en && (wr_vc == VW'(v));
      w_pop[v]    = w_out_new && (r_cur_vc == VW'(v));
      w_push[v]   = w_wr_sel[v] && (!w_full[v] || w_pop[v]);
      if (w_wr_sel[v] && w_full[v] && !w_pop[v]) w_ovf = 1'b1;
    end
    w_empty_after = w_out_new && (w_count[r_cur_vc] == CW'(1)) && !w_push[r_cur_vc];
    w_burst_done  = w_out_new && (r_burst_cnt == BW'(max_burst - 1));
    w_leave       = !w_out_new || w_empty_after || w_burst_done;
    w_cur_inc     = (r_cur_vc == VW'(no_vc - 1)) ? '0 : r_cur_vc + VW'(1);
  end

  // Find first eligible VC at or after the start pointer, cyclically.
  always_comb begin
    int idx;
    idx         = 0;
    w_mask      = ~w_empty;
    w_start     = int'(r_rr_ptr);
    w_mask_excl = '0;
    if (r_state == ST_SEND) begin
      w_start = int'(w_cur_inc);
      if (w_empty_after) w_mask[r_cur_vc] = 1'b0;
      w_mask_excl = w_mask;
      w_mask_excl[r_cur_vc] = 1'b0;
      if (!w_out_new && (w_mask_excl != '0)) w_mask = w_mask_excl;
    end
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int i = 0; i < no_vc; i++) begin
      idx = w_start + i;
      if (idx >= no_vc) idx = idx - no_vc;
      if (!w_pick_valid && w_mask[idx]) begin
        w_pick_valid = 1'b1;
        w_pick       = VW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rs) r_state <= ST_IDLE;
    else    r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_valid) w_next_state = ST_PROBE;
      ST_PROBE: w_next_state = ST_SEND;
      ST_SEND:  if (w_leave) w_next_state = w_pick_valid ? ST_PROBE : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_out_new   = (r_state == ST_SEND) && ready && !w_empty[r_cur_vc];
    out_new     = w_out_new;
    outdata     = w_out_new ? w_head_arr[r_cur_vc][phit_size-1:0] : '0;
    outsent_req = w_out_new ? w_head_arr[r_cur_vc][phit_size] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_cur_vc    <= '0;
      r_rr_ptr    <= '0;
      r_outvc_no  <= '0;
      r_burst_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_next_state == ST_PROBE) begin
        r_cur_vc   <= w_pick;
        r_outvc_no <= w_pick;
      end
      if (r_state == ST_SEND) begin
        if (w_leave) begin
          r_rr_ptr    <= w_cur_inc;
          r_burst_cnt <= '0;
        end else if (w_out_new) begin
          r_burst_cnt <= r_burst_cnt + BW'(1);
        end
      end
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign full_vec    = w_full;
  assign ovf_err     = r_ovf;
  assign outvc_no    = r_outvc_no;
  assign o_dbg_state = r_state;

endmodule
